// File: rtl/ext_cpu_obi_arbiter.sv
// Round-robin OBI arbiter sharing one slave port between NHARTS master ports.
// Optional per-master grant counters are built when EXT_OBI_ARB_PERF_EN is defined.

package ext_cpu_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

// Generic synchronous FIFO with wrap-around pointers and a separate occupancy counter.
// Latency: pushed entry visible at pop_dat one cycle after the push.
// Backpressure: push_rdy drops when full; a pop at full does not free the slot for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_rdy & pop_vld;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Round-robin arbiter: forwards one master request to the shared slave and routes responses back in order.
// Latency: zero cycles on both request/grant and response paths (purely combinational forwarding).
// Backpressure: slave gnt=0 locks the selected master; a full ID FIFO holds slv_req_o.req low.
module ext_cpu_obi_arbiter
    import ext_cpu_obi_pkg::*;
#(
    parameter int NHARTS          = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  obi_req_t  [NHARTS-1:0]       mst_req_i,
    output obi_resp_t [NHARTS-1:0]       mst_resp_o,
    output obi_req_t                     slv_req_o,
    input  obi_resp_t                    slv_resp_i,
    output logic                         spurious_o
`ifdef EXT_OBI_ARB_PERF_EN
    ,
    output logic [NHARTS-1:0][CNT_W-1:0] grant_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NHARTS);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock_vld;
    logic [IDX_W-1:0] sel;
    logic             sel_vld;
    logic             fwd_req;
    logic             accept;
    logic             pop;
    logic             fifo_push_rdy;
    logic             fifo_pop_vld;
    logic [IDX_W-1:0] head;

    // Descending scan so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        int j;
        j       = 0;
        sel     = '0;
        sel_vld = 1'b0;
        if (lock_vld) begin
            sel     = lock_idx;
            sel_vld = mst_req_i[lock_idx].req;
        end else begin
            for (int i = NHARTS - 1; i >= 0; i--) begin
                j = int'(rr_ptr) + i;
                if (j >= NHARTS) begin
                    j = j - NHARTS;
                end
                if (mst_req_i[IDX_W'(j)].req) begin
                    sel     = IDX_W'(j);
                    sel_vld = 1'b1;
                end
            end
        end
    end

    assign fwd_req = sel_vld & fifo_push_rdy & ~rst_i;
    assign accept  = fwd_req & slv_resp_i.gnt;
    assign pop     = slv_resp_i.rvalid & fifo_pop_vld & ~rst_i;

    always_comb begin
        slv_req_o  = '0;
        mst_resp_o = '0;
        spurious_o = slv_resp_i.rvalid & ~fifo_pop_vld & ~rst_i;
        if (fwd_req) begin
            slv_req_o = mst_req_i[sel];
        end
        if (accept) begin
            mst_resp_o[sel].gnt = 1'b1;
        end
        if (pop) begin
            mst_resp_o[head].rvalid = 1'b1;
            mst_resp_o[head].rdata  = slv_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else begin
            lock_vld <= fwd_req & ~slv_resp_i.gnt;
            if (fwd_req) begin
                lock_idx <= sel;
            end
            if (accept) begin
                rr_ptr <= (sel == IDX_W'(NHARTS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (accept),
        .push_dat (sel),
        .push_rdy (fifo_push_rdy),
        .pop_vld  (fifo_pop_vld),
        .pop_dat  (head),
        .pop_rdy  (pop)
    );

`ifdef EXT_OBI_ARB_PERF_EN
    logic [NHARTS-1:0][CNT_W-1:0] grant_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt <= '0;
        end else if (accept && (grant_cnt[sel] != '1)) begin
            grant_cnt[sel] <= grant_cnt[sel] + 1'b1;
        end
    end

    assign grant_cnt_o = rst_i ? '0 : grant_cnt;
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: doc/ext_cpu_obi_arbiter.md
# ext_cpu_obi_arbiter

Round-robin arbiter that shares one OBI slave port between the NHARTS data (or instruction) master ports of the external CPU system. It sits between the per-hart `core_data_req_o`/`core_data_resp_i` bundles and a single bus port. It keeps OBI request stability, tracks in-order outstanding transactions in an ID FIFO, and routes each response back to the hart that issued it.

## Interface
- NHARTS, 2, number of master ports (≥2)
- MAX_OUTSTANDING, 2, depth of outstanding-transaction ID FIFO (≥1)
- CNT_W, 16, width of per-master grant counters (only used with EXT_OBI_ARB_PERF_EN)
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- mst_req_i  input  obi_req_t[NHARTS]  master requests (req, we, be, addr, wdata)
- mst_resp_o  output  obi_resp_t[NHARTS]  master responses (gnt, rvalid, rdata)
- slv_req_o  output  obi_req_t  forwarded request to shared port
- slv_resp_i  input  obi_resp_t  shared-port response
- spurious_o  output  1  one-cycle pulse: slave rvalid arrived with FIFO empty
- grant_cnt_o  output  [NHARTS][CNT_W]  per-master accepted-request count (EXT_OBI_ARB_PERF_EN only)

## Operation
- Selection: among masters with req=1, pick the first index at or after `rr_ptr`, wrapping modulo NHARTS.
- Lock: if slv_req_o.req=1 and slv_resp_i.gnt=0, register the selected index (`lock_vld`=1). While locked, the selection is the locked index regardless of other requests, which keeps addr/we/be/wdata stable per OBI. The lock clears on the cycle gnt is received.
- Forwarding: slv_req_o carries the selected master's fields. slv_req_o.req = selected req & ~fifo_full. With no requester or with the FIFO full: slv_req_o.req=0 and other fields are 0.
- Accept: a request is accepted when slv_req_o.req & slv_resp_i.gnt. On accept:
  - mst_resp_o[sel].gnt=1 in the same cycle.
  - Push sel into the ID FIFO.
  - rr_ptr ← (sel+1) mod NHARTS.
- Non-selected masters: gnt=0.
- Response routing: on slv_resp_i.rvalid with FIFO non-empty:
  - mst_resp_o[head].rvalid=1 and mst_resp_o[head].rdata = slv_resp_i.rdata.
  - Pop the FIFO.
  - All other masters: rvalid=0, rdata=0.
- Spurious response: rvalid with FIFO empty is dropped, spurious_o=1 for that cycle, no state change.
- FIFO full: grants are blocked even if a pop happens in the same cycle (no push-through at full). Push and pop in the same cycle when not full: occupancy unchanged, order preserved.
- Pointer arithmetic: FIFO read/write pointers wrap modulo MAX_OUTSTANDING, with occupancy held in a separate counter of $clog2(MAX_OUTSTANDING+1) bits. rr_ptr is $clog2(NHARTS) bits and wraps explicitly at NHARTS-1→0.

## Timing
- Request path is combinational, zero cycles: mst req → slv_req_o in the same cycle; slv gnt → mst gnt in the same cycle.
- Response path is combinational, zero cycles: slv rvalid/rdata → mst rvalid/rdata in the same cycle.
- Minimum response latency is 1 cycle after accept (OBI). A response in the same cycle as its own accept is not supported.
- Reset (rst_i=1 at a clock edge) clears:
  - rr_ptr=0, lock_vld=0, FIFO empty (pointers 0, count 0), grant counters 0.
- While rst_i=1, all outputs are 0: slv_req_o all fields, every mst_resp_o field, spurious_o, and grant_cnt_o. Assertion mid-transaction discards all outstanding IDs; later responses count as spurious.
- Fairness: under continuous requests from all masters, each master is granted at least once every NHARTS accepts.

## Configuration
- EXT_OBI_ARB_PERF_EN defined:
  - grant_cnt_o exists.
  - grant_cnt_o[i] increments by 1 on each accept for master i and saturates at 2^CNT_W−1.
  - Cleared only by reset.
- EXT_OBI_ARB_PERF_EN undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Single requester: master 1 req with addr 0x2001_0040, slave gnt the same cycle, rvalid 2 cycles later with rdata 0xDEAD_BEEF → mst1 gnt in the same cycle, mst1 rvalid/rdata=0xDEAD_BEEF, mst0 sees nothing.
- Round-robin: both masters request continuously, slave gnt always 1, rvalid 1 cycle after each accept → accepts alternate 0,1,0,1 starting with 0 after reset.
- Lock: master 0 is selected, slave withholds gnt for 3 cycles while master 1 also requests → slv_req_o.addr equals master 0's address for all 4 cycles. Master 0 is granted first, then master 1.
- FIFO full: MAX_OUTSTANDING=2, two accepts with no rvalid → third request sees slv_req_o.req=0. A same-cycle rvalid does not grant; the grant comes on the next cycle.
- Out-of-band events:
  - rvalid with empty FIFO → spurious_o=1 for one cycle, no mst rvalid.
  - rst_i asserted with 1 outstanding → all outputs 0, next rvalid is spurious.
- Perf (macro on, CNT_W=4): 17 accepts for master 0 → grant_cnt_o[0]=15 (saturated), grant_cnt_o[1]=0.
